// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default baud divisor.
// Used by the receiver and the future transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop synchronizer for a single asynchronous input; flops reset to RESET_VAL.
// Also intended for the KEY inputs.
module bit_sync #(
    parameter int unsigned N         = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output, framing-error and overrun pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 baud_done;
    logic                 still_held;

    bit_sync #(
        .N         (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    assign baud_done  = (baud_cnt == BAUD_LAST);
    // A byte accepted on this edge frees the output register for a byte completing on the same edge.
    assign still_held = data_valid & ~data_ready;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                START: begin
                    if (baud_cnt == BAUD_MID) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        par_bit  <= rxs;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bit != even_parity(shift_reg)) begin
                                parity_err <= 1'b1;
                            end else if (still_held) begin
                                overrun <= 1'b1;
                            end else begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end
`else
                            if (still_held) begin
                                overrun <= 1'b1;
                            end else begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    baud_cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    int unsigned acc_cnt = 0;
    int unsigned fe_cnt  = 0;
    int unsigned ov_cnt  = 0;
    int unsigned pe_cnt  = 0;
    logic [7:0]  last_byte = 8'h00;

    int unsigned acc0, fe0, ov0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Inputs change at negedge or posedge+1, so negedge observes settled values.
    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            acc_cnt   = acc_cnt + 1;
            last_byte = data_out;
        end
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        acc0 = acc_cnt;
        fe0  = fe_cnt;
        ov0  = ov_cnt;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 data_ready = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop;
        repeat (CPB) @(negedge clk);
        #1;
    endtask

    initial begin
        rx         = 1'b1;
        data_ready = 1'b1;
        rst_n      = 1'b0;
        wait_cycles(4);
        chk("reset data_out",   32'(data_out),   32'h00);
        chk("reset data_valid", 32'(data_valid), 32'h0);
        chk("reset frame_err",  32'(frame_err),  32'h0);
        chk("reset overrun",    32'(overrun),    32'h0);
        chk("reset parity_err", 32'(parity_err), 32'h0);
        rst_n = 1'b1;
        wait_cycles(20);

        // Basic reception with an always-ready consumer
        snap();
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cycles(8);
        chk("A5 accept count", acc_cnt - acc0, 1);
        chk("A5 data",         32'(last_byte), 32'hA5);
        chk("A5 frame_err",    fe_cnt - fe0, 0);
        chk("A5 overrun",      ov_cnt - ov0, 0);
        chk("A5 valid low",    32'(data_valid), 32'h0);

        snap();
        send_frame(8'hC1, 1'b1, 1'b1);
        wait_cycles(8);
        chk("C1 accept count", acc_cnt - acc0, 1);
        chk("C1 data",         32'(last_byte), 32'hC1);

        // Short low glitch is rejected at the start-bit midpoint
        snap();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        wait_cycles(60);
        chk("glitch accept count", acc_cnt - acc0, 0);
        chk("glitch frame_err",    fe_cnt - fe0, 0);
        chk("glitch valid",        32'(data_valid), 32'h0);

        // Bad stop bit, then a long break
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cycles(100);
        chk("break frame_err count", fe_cnt - fe0, 1);
        chk("break accept count",    acc_cnt - acc0, 0);
        chk("break valid",           32'(data_valid), 32'h0);
        rx = 1'b1;
        wait_cycles(20);
        send_frame(8'h81, 1'b0, 1'b1);
        wait_cycles(8);
        chk("81 accept count",      acc_cnt - acc0, 1);
        chk("81 data",              32'(last_byte), 32'h81);
        chk("81 no new frame_err",  fe_cnt - fe0, 1);

        // Stalled consumer: second back-to-back byte overruns
        set_ready(1'b0);
        snap();
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        wait_cycles(4);
        chk("ovr valid held",   32'(data_valid), 32'h1);
        chk("ovr data held",    32'(data_out),   32'h11);
        chk("ovr pulse count",  ov_cnt - ov0, 1);
        chk("ovr accept count", acc_cnt - acc0, 0);
        set_ready(1'b1);
        wait_cycles(3);
        chk("ovr drain count",  acc_cnt - acc0, 1);
        chk("ovr drain data",   32'(last_byte), 32'h11);
        chk("ovr drain valid",  32'(data_valid), 32'h0);

        // Reset mid-frame while a byte is pending
        set_ready(1'b0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cycles(2);
        chk("pending valid", 32'(data_valid), 32'h1);
        chk("pending data",  32'(data_out),   32'h5A);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(i & 1);
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst data_out",   32'(data_out),   32'h00);
        chk("midrst data_valid", 32'(data_valid), 32'h0);
        chk("midrst frame_err",  32'(frame_err),  32'h0);
        chk("midrst overrun",    32'(overrun),    32'h0);
        rx = 1'b1;
        data_ready = 1'b1;
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(40);
        chk("postrst no output", acc_cnt - acc0, 0);
        send_frame(8'h7E, 1'b0, 1'b1);
        wait_cycles(8);
        chk("7E accept count", acc_cnt - acc0, 1);
        chk("7E data",         32'(last_byte), 32'h7E);
        chk("7E frame_err",    fe_cnt - fe0, 0);
        chk("7E overrun",      ov_cnt - ov0, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cycles(8);
        chk("par bad pulse",  pe_cnt, 1);
        chk("par bad accept", acc_cnt - acc0, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(8);
        chk("par good accept", acc_cnt - acc0, 1);
        chk("par good data",   32'(last_byte), 32'h07);
        chk("par good pulse",  pe_cnt, 1);
`else
        chk("parity_err never", pe_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
